// File: rtl/rca_nibble_serial_controller.sv
// Nibble-serial W-bit add/subtract sequencer driving one shared external 4-bit ripple-carry adder.
// Operands are processed LSB nibble first, one nibble per clock, with a registered inter-nibble carry.
module rca_nibble_serial_controller #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4*NIBBLES-1:0]   req_a,
    input  logic [4*NIBBLES-1:0]   req_b,
    input  logic                   req_cin,
    input  logic                   req_sub,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_ovf,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    logic [1:0]       state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     sum_reg;
    logic             carry_reg;
    logic [W-1:0]     rsp_sum_reg;
    logic             rsp_cout_reg;
    logic             rsp_ovf_reg;

    logic [3:0]       a_nib [NIBBLES];
    logic [3:0]       b_nib [NIBBLES];
    logic [W-1:0]     sum_next;
    logic [3:0]       a_sel;
    logic [3:0]       b_sel;
    logic             in_run;
    logic             last_nibble;
    logic             ovf_next;

    // Slice the operands into nibbles and splice the adder result into the current slot.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
            assign sum_next[4*gi +: 4] = (idx_reg == IDX_W'(gi)) ? add_sum : sum_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        a_sel = 4'd0;
        b_sel = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                a_sel = a_nib[i];
                b_sel = b_nib[i];
            end
        end
    end

    assign in_run      = (state_reg == ST_RUN);
    assign last_nibble = in_run && (idx_reg == IDX_LAST);

    // b_reg already holds ~B for subtraction, so one overflow rule covers both operations.
    assign ovf_next = (a_reg[W-1] == b_reg[W-1]) && (sum_next[W-1] != a_reg[W-1]);

    assign add_a     = in_run ? a_sel : 4'd0;
    assign add_b     = in_run ? b_sel : 4'd0;
    assign add_cin   = in_run ? carry_reg : 1'b0;

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_DONE);
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_cout  = rsp_cout_reg;
    assign rsp_ovf   = rsp_ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            sum_reg      <= '0;
            carry_reg    <= 1'b0;
            rsp_sum_reg  <= '0;
            rsp_cout_reg <= 1'b0;
            rsp_ovf_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_reg     <= req_a;
                        b_reg     <= req_sub ? ~req_b : req_b;
                        carry_reg <= req_sub ? 1'b1 : req_cin;
                        idx_reg   <= '0;
                        sum_reg   <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= add_cout;
                    if (last_nibble) begin
                        // Response registers load only here so they hold between operations.
                        idx_reg      <= '0;
                        rsp_sum_reg  <= sum_next;
                        rsp_cout_reg <= add_cout;
                        rsp_ovf_reg  <= ovf_next;
                        state_reg    <= ST_DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_nibble_serial_controller.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor pops them on each response handshake.
module tb_rca_nibble_serial_controller;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         req_cin = 1'b0;
    logic         req_sub = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;

    always #5 clk = ~clk;

    // Behavioural stand-in for the external combinational 4-bit adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    rca_nibble_serial_controller #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } rsp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    rsp_t       exp_q[$];
    vec_t       vecs[9];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] seq_a   [8];
    logic       seq_cin [8];
    int         lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every taken response against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                $display("rsp: sum=0x%04h cout=%0b ovf=%0b (expected 0x%04h %0b %0b)",
                         rsp_sum, rsp_cout, rsp_ovf, e.sum, e.cout, e.ovf);
                chk("rsp_sum",  32'(rsp_sum),  32'(e.sum));
                chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                chk("rsp_ovf",  32'(rsp_ovf),  32'(e.ovf));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_sum"},   32'(rsp_sum),   32'd0);
        chk({tag, "_rsp_cout"},  32'(rsp_cout),  32'd0);
        chk({tag, "_rsp_ovf"},   32'(rsp_ovf),   32'd0);
        chk({tag, "_add_a"},     32'(add_a),     32'd0);
        chk({tag, "_add_b"},     32'(add_b),     32'd0);
        chk({tag, "_add_cin"},   32'(add_cin),   32'd0);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub,
                         input logic [W-1:0] es, input logic ec, input logic eo, input logic expect_rsp);
        rsp_t e;
        @(posedge clk); #2;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_sub   = sub;
        if (expect_rsp) begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int latency);
        latency = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            latency++;
            if (rsp_valid) break;
            if (latency <= 8) begin
                seq_a[latency-1]   = add_a;
                seq_cin[latency-1] = add_cin;
            end
        end
        if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        $display("op: a=0x%04h b=0x%04h cin=%0b sub=%0b", v.a, v.b, v.cin, v.sub);
        issue(v.a, v.b, v.cin, v.sub, v.sum, v.cout, v.ovf, 1'b1);
        wait_accept();
        wait_rsp(lat);
        chk("latency", 32'(lat), 32'(NIBBLES + 1));
        @(posedge clk); #2;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h0003, 16'h0004, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        #1 rst_n = 1'b0;
        #2 chk_reset_outputs("por");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
            if (i == 0) begin
                chk("seq_a0", 32'(seq_a[0]), 32'h4);
                chk("seq_a1", 32'(seq_a[1]), 32'h3);
                chk("seq_a2", 32'(seq_a[2]), 32'h2);
                chk("seq_a3", 32'(seq_a[3]), 32'h1);
            end
            if (i == 1) begin
                chk("seq_cin0", 32'(seq_cin[0]), 32'd0);
                chk("seq_cin1", 32'(seq_cin[1]), 32'd1);
                chk("seq_cin2", 32'(seq_cin[2]), 32'd1);
                chk("seq_cin3", 32'(seq_cin[3]), 32'd1);
            end
        end
        chk("idle_add_a", 32'(add_a), 32'd0);

        // Backpressure: response must hold while a second request waits outside IDLE.
        $display("op: backpressure 0x0100+0x0023 then 0x4000-0x1000");
        rsp_ready = 1'b0;
        issue(16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b1);
        wait_accept();
        wait_rsp(lat);
        chk("bp_latency", 32'(lat), 32'(NIBBLES + 1));
        issue(16'h4000, 16'h1000, 1'b0, 1'b1, 16'h3000, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_sum",   32'(rsp_sum),   32'h0123);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_add_a",     32'(add_a),     32'd0);
        end
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_req_ready_at_hs", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("bp_req_ready_after_hs", 32'(req_ready), 32'd1);
        @(posedge clk); #2;
        req_valid = 1'b0;
        wait_rsp(lat);
        chk("bp2_latency", 32'(lat), 32'(NIBBLES + 1));
        chk("bp2_seq_a3", 32'(seq_a[3]), 32'h4);
        @(posedge clk); #2;

        // Reset in the middle of RUN discards the operation.
        $display("op: 0x1111+0x2222 aborted by reset at idx=2");
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        wait_accept();
        repeat (3) @(negedge clk);
        chk("mid_run_add_a", 32'(add_a), 32'h1);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("mid_run");
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        run_vec('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
